// File: rtl/activation_rdma_pkg.sv
// rtl/activation_rdma_pkg.sv - shared CNN sizing constants, FSM states and burst-length helper for the activation read DMA
package activation_rdma_pkg;

  localparam int TOUT               = 4;
  localparam int MAX_DAT_DW         = 16;
  localparam int DAT_W              = TOUT * MAX_DAT_DW;
  localparam int AXI_BURST_LEN      = 16;
  localparam int LOG2_AXI_BURST_LEN = 4;
  localparam int PIXEL_DATA_BYTES   = 64;
  localparam int LOG2_W             = 10;
  localparam int LOG2_H             = 10;
  localparam int LOG2_CH            = 10;
  localparam int LOG2_TOUT          = 2;
  localparam int CH_W               = LOG2_CH - LOG2_TOUT;
  localparam int ACT_RD_REQ_PD_W    = LOG2_AXI_BURST_LEN + 32;
  localparam int BURST_BYTES        = AXI_BURST_LEN * PIXEL_DATA_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } rdma_state_e;

  // Last burst of a line carries the remainder; a zero remainder wraps to a full burst.
  function automatic logic [LOG2_AXI_BURST_LEN-1:0] burst_len(
    input logic              last_bt,
    input logic [LOG2_W-1:0] w
  );
    logic [LOG2_AXI_BURST_LEN-1:0] w_rem;
    w_rem = w[LOG2_AXI_BURST_LEN-1:0];
    return last_bt ? (w_rem - 1'b1) : {LOG2_AXI_BURST_LEN{1'b1}};
  endfunction

endpackage

// File: rtl/activation_rdma_addr_gen.sv
// rtl/activation_rdma_addr_gen.sv - burst/line/slice walker producing the registered address, length and last flag
module activation_rdma_addr_gen
  import activation_rdma_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init,
  input  logic                          step,
  input  logic [LOG2_W-1:0]             w,
  input  logic [LOG2_H-1:0]             h,
  input  logic [CH_W-1:0]               ch_div_tout,
  input  logic [31:0]                   base_addr,
  input  logic [25:0]                   surface_stride,
  input  logic [15:0]                   line_stride,
  output logic [31:0]                   addr,
  output logic [LOG2_AXI_BURST_LEN-1:0] len,
  output logic                          last
);

  localparam int BT_W = LOG2_W - LOG2_AXI_BURST_LEN;

  logic [LOG2_W-1:0]             r_w;
  logic [LOG2_H-1:0]             r_h;
  logic [CH_W-1:0]               r_ch;
  logic [25:0]                   r_ss;
  logic [15:0]                   r_ls;
  logic [BT_W-1:0]               r_bt;
  logic [LOG2_H-1:0]             r_ln;
  logic [CH_W-1:0]               r_cs;
  logic [31:0]                   r_surf_bias;
  logic [31:0]                   r_line_bias;
  logic [31:0]                   r_addr;
  logic [LOG2_AXI_BURST_LEN-1:0] r_len;
  logic                          r_last;

  logic [LOG2_W-1:0]             w_cfg_w;
  logic [LOG2_W-1:0]             w_wm1;
  logic [BT_W-1:0]               w_bt_max;
  logic [LOG2_H-1:0]             w_ln_max;
  logic [CH_W-1:0]               w_cs_max;
  logic [31:0]                   w_line_inc;
  logic [31:0]                   w_surf_inc;
  logic [BT_W-1:0]               w_bt_nxt;
  logic [LOG2_H-1:0]             w_ln_nxt;
  logic [CH_W-1:0]               w_cs_nxt;
  logic [31:0]                   w_surf_nxt;
  logic [31:0]                   w_line_nxt;
  logic [31:0]                   w_addr_nxt;
  logic [LOG2_AXI_BURST_LEN-1:0] w_len_nxt;
  logic                          w_last_nxt;

  // On init the loop limits come straight from the inputs so the first command is ready next cycle.
  assign w_cfg_w    = init ? w : r_w;
  assign w_wm1      = w_cfg_w - 1'b1;
  assign w_bt_max   = w_wm1[LOG2_W-1:LOG2_AXI_BURST_LEN];
  assign w_ln_max   = (init ? h : r_h) - 1'b1;
  assign w_cs_max   = (init ? ch_div_tout : r_ch) - 1'b1;
  assign w_line_inc = r_line_bias + {16'd0, r_ls};
  assign w_surf_inc = r_surf_bias + {6'd0, r_ss};

  always_comb begin
    w_bt_nxt   = r_bt;
    w_ln_nxt   = r_ln;
    w_cs_nxt   = r_cs;
    w_surf_nxt = r_surf_bias;
    w_line_nxt = r_line_bias;
    w_addr_nxt = r_addr;
    if (init) begin
      w_bt_nxt   = '0;
      w_ln_nxt   = '0;
      w_cs_nxt   = '0;
      w_surf_nxt = base_addr;
      w_line_nxt = base_addr;
      w_addr_nxt = base_addr;
    end else if (step) begin
      if (r_bt != w_bt_max) begin
        w_bt_nxt   = r_bt + 1'b1;
        w_addr_nxt = r_addr + 32'(BURST_BYTES);
      end else if (r_ln != w_ln_max) begin
        w_bt_nxt   = '0;
        w_ln_nxt   = r_ln + 1'b1;
        w_line_nxt = w_line_inc;
        w_addr_nxt = w_line_inc;
      end else if (r_cs != w_cs_max) begin
        w_bt_nxt   = '0;
        w_ln_nxt   = '0;
        w_cs_nxt   = r_cs + 1'b1;
        w_surf_nxt = w_surf_inc;
        w_line_nxt = w_surf_inc;
        w_addr_nxt = w_surf_inc;
      end
    end
    w_len_nxt  = burst_len(w_bt_nxt == w_bt_max, w_cfg_w);
    w_last_nxt = (w_bt_nxt == w_bt_max) && (w_ln_nxt == w_ln_max) && (w_cs_nxt == w_cs_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w         <= '0;
      r_h         <= '0;
      r_ch        <= '0;
      r_ss        <= '0;
      r_ls        <= '0;
      r_bt        <= '0;
      r_ln        <= '0;
      r_cs        <= '0;
      r_surf_bias <= '0;
      r_line_bias <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_last      <= 1'b0;
    end else if (init || step) begin
      if (init) begin
        r_w  <= w;
        r_h  <= h;
        r_ch <= ch_div_tout;
        r_ss <= surface_stride;
        r_ls <= line_stride;
      end
      r_bt        <= w_bt_nxt;
      r_ln        <= w_ln_nxt;
      r_cs        <= w_cs_nxt;
      r_surf_bias <= w_surf_nxt;
      r_line_bias <= w_line_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign addr = r_addr;
  assign len  = r_len;
  assign last = r_last;

endmodule

// File: rtl/activation_rdma.sv
// rtl/activation_rdma.sv - activation feature-map read DMA: command FSM, beat credit counter, response pass-through
module activation_rdma
  import activation_rdma_pkg::*;
#(
  parameter int MAX_OUT_BEATS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LOG2_W-1:0]          w,
  input  logic [LOG2_H-1:0]          h,
  input  logic [CH_W-1:0]            ch_div_Tout,
  input  logic [31:0]                feature_base_addr,
  input  logic [25:0]                feature_surface_stride,
  input  logic [15:0]                feature_line_stride,
  output logic                       rdma_done,
  output logic                       rdma_busy,
  output logic                       ACT2mcif_rd_req_vld,
  input  logic                       ACT2mcif_rd_req_rdy,
  output logic [ACT_RD_REQ_PD_W-1:0] ACT2mcif_rd_req_pd,
  input  logic                       mcif2ACT_rd_rsp_vld,
  input  logic [DAT_W-1:0]           mcif2ACT_rd_rsp_pd,
  output logic                       mcif2ACT_rd_rsp_rdy,
  output logic                       dat_out_vld,
  output logic [DAT_W-1:0]           dat_out_pd,
  input  logic                       dat_out_rdy
);

  localparam int OUT_W = $clog2(MAX_OUT_BEATS) + 1;
  localparam logic [OUT_W-1:0] ONE_O   = OUT_W'(1);
  localparam logic [OUT_W:0]   ONE_N   = (OUT_W + 1)'(1);
  localparam logic [OUT_W:0]   MAX_N   = (OUT_W + 1)'(MAX_OUT_BEATS);

  rdma_state_e                   r_state;
  rdma_state_e                   w_state_nxt;
  logic [OUT_W-1:0]              r_outstanding;
  logic                          r_done;
  logic                          w_done_nxt;

  logic                          w_init;
  logic [31:0]                   w_gen_addr;
  logic [LOG2_AXI_BURST_LEN-1:0] w_gen_len;
  logic                          w_gen_last;
  logic [OUT_W-1:0]              w_len_ext;
  logic [OUT_W:0]                w_need;
  logic                          w_req_vld;
  logic                          w_cmd_fire;
  logic                          w_dat_fire;
  logic [OUT_W-1:0]              w_add;
  logic [OUT_W-1:0]              w_sum;
  logic [OUT_W-1:0]              w_out_nxt;

  assign w_init = start && (r_state == ST_IDLE);

  activation_rdma_addr_gen u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .init           (w_init),
    .step           (w_cmd_fire),
    .w              (w),
    .h              (h),
    .ch_div_tout    (ch_div_Tout),
    .base_addr      (feature_base_addr),
    .surface_stride (feature_surface_stride),
    .line_stride    (feature_line_stride),
    .addr           (w_gen_addr),
    .len            (w_gen_len),
    .last           (w_gen_last)
  );

  // One extra bit on the credit sum keeps the comparison free of wrap-around.
  assign w_len_ext  = OUT_W'(w_gen_len);
  assign w_need     = {1'b0, r_outstanding} + {1'b0, w_len_ext} + ONE_N;
  assign w_req_vld  = (r_state == ST_REQ) && (w_need <= MAX_N);
  assign w_cmd_fire = w_req_vld && ACT2mcif_rd_req_rdy;
  assign w_dat_fire = mcif2ACT_rd_rsp_vld && dat_out_rdy;

  // Stray beats with nothing outstanding leave the counter at zero.
  assign w_add     = w_cmd_fire ? (w_len_ext + ONE_O) : '0;
  assign w_sum     = r_outstanding + w_add;
  assign w_out_nxt = (w_dat_fire && (w_sum != '0)) ? (w_sum - ONE_O) : w_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (w_cmd_fire && w_gen_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_nxt == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_outstanding <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign ACT2mcif_rd_req_vld = w_req_vld;
  assign ACT2mcif_rd_req_pd  = {w_gen_len, w_gen_addr};
  assign rdma_done           = r_done;
  assign rdma_busy           = (r_state != ST_IDLE);
  assign mcif2ACT_rd_rsp_rdy = dat_out_rdy;
  assign dat_out_vld         = mcif2ACT_rd_rsp_vld;
  assign dat_out_pd          = mcif2ACT_rd_rsp_pd;

endmodule

// File: tb/tb_activation_rdma.sv
// tb/tb_activation_rdma.sv - randomized self-checking bench for activation_rdma against a loop-nest command model
module tb_activation_rdma;
  import activation_rdma_pkg::*;

  localparam int MAXB = 16;

  typedef struct {
    logic [31:0]                   addr;
    logic [LOG2_AXI_BURST_LEN-1:0] len;
  } cmd_t;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       start = 1'b0;
  logic [LOG2_W-1:0]          w = '0;
  logic [LOG2_H-1:0]          h = '0;
  logic [CH_W-1:0]            ch_div_Tout = '0;
  logic [31:0]                feature_base_addr = '0;
  logic [25:0]                feature_surface_stride = '0;
  logic [15:0]                feature_line_stride = '0;
  logic                       rdma_done;
  logic                       rdma_busy;
  logic                       ACT2mcif_rd_req_vld;
  logic                       ACT2mcif_rd_req_rdy = 1'b0;
  logic [ACT_RD_REQ_PD_W-1:0] ACT2mcif_rd_req_pd;
  logic                       mcif2ACT_rd_rsp_vld = 1'b0;
  logic [DAT_W-1:0]           mcif2ACT_rd_rsp_pd = '0;
  logic                       mcif2ACT_rd_rsp_rdy;
  logic                       dat_out_vld;
  logic [DAT_W-1:0]           dat_out_pd;
  logic                       dat_out_rdy = 1'b0;

  activation_rdma #(.MAX_OUT_BEATS(MAXB)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .w                      (w),
    .h                      (h),
    .ch_div_Tout            (ch_div_Tout),
    .feature_base_addr      (feature_base_addr),
    .feature_surface_stride (feature_surface_stride),
    .feature_line_stride    (feature_line_stride),
    .rdma_done              (rdma_done),
    .rdma_busy              (rdma_busy),
    .ACT2mcif_rd_req_vld    (ACT2mcif_rd_req_vld),
    .ACT2mcif_rd_req_rdy    (ACT2mcif_rd_req_rdy),
    .ACT2mcif_rd_req_pd     (ACT2mcif_rd_req_pd),
    .mcif2ACT_rd_rsp_vld    (mcif2ACT_rd_rsp_vld),
    .mcif2ACT_rd_rsp_pd     (mcif2ACT_rd_rsp_pd),
    .mcif2ACT_rd_rsp_rdy    (mcif2ACT_rd_rsp_rdy),
    .dat_out_vld            (dat_out_vld),
    .dat_out_pd             (dat_out_pd),
    .dat_out_rdy            (dat_out_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  cmd_t             exp_q[$];
  logic [DAT_W-1:0] sent_q[$];
  logic [DAT_W-1:0] recv_q[$];
  int               total_beats, pending, model_out, fired;
  bit               active, drain, exp_done, busy_exp, holding, stalled, start_req, g_block;
  logic [DAT_W-1:0] cur_data;
  logic [ACT_RD_REQ_PD_W-1:0] prev_pd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected commands straight from the loop nest and the address formula.
  task automatic build_model(input int cw, input int ch_h, input int cch,
                             input int unsigned cbase, input int unsigned cls, input int unsigned css);
    int   nb;
    cmd_t e;
    exp_q.delete();
    total_beats = 0;
    nb = (cw + AXI_BURST_LEN - 1) / AXI_BURST_LEN;
    for (int cs = 0; cs < cch; cs++)
      for (int ln = 0; ln < ch_h; ln++)
        for (int bt = 0; bt < nb; bt++) begin
          int unsigned a;
          a = cbase + cs * css + ln * cls + bt * AXI_BURST_LEN * PIXEL_DATA_BYTES;
          e.addr = a;
          e.len  = (bt == nb - 1) ? LOG2_AXI_BURST_LEN'((cw - 1) % AXI_BURST_LEN)
                                  : LOG2_AXI_BURST_LEN'(AXI_BURST_LEN - 1);
          exp_q.push_back(e);
          total_beats += int'(e.len) + 1;
        end
  endtask

  task automatic reset_model();
    pending = 0; model_out = 0; fired = 0;
    active = 0; drain = 0; exp_done = 0; busy_exp = 0;
    holding = 0; stalled = 0; start_req = 0; g_block = 0;
    sent_q.delete(); recv_q.delete();
  endtask

  task automatic cycle(input int req_pct, input int dat_pct);
    bit   cf, df, done_now;
    cmd_t e;
    @(negedge clk);
    ACT2mcif_rd_req_rdy = ($urandom_range(99) < req_pct);
    dat_out_rdy         = ($urandom_range(99) < dat_pct);
    if (pending > 0) begin
      if (!holding) begin
        cur_data = {$urandom, $urandom};
        holding  = 1;
      end
      mcif2ACT_rd_rsp_vld = 1'b1;
      mcif2ACT_rd_rsp_pd  = cur_data;
    end else begin
      mcif2ACT_rd_rsp_vld = 1'b0;
      mcif2ACT_rd_rsp_pd  = {$urandom, $urandom};
    end
    start     = start_req;
    start_req = 0;
    #1;
    done_now = exp_done;
    exp_done = 0;
    check("done", rdma_done, done_now);
    if (done_now) begin
      active = 0; drain = 0; busy_exp = 0;
    end
    check("busy", rdma_busy, busy_exp);
    check("vld_pass", dat_out_vld, mcif2ACT_rd_rsp_vld);
    check("pd_pass", dat_out_pd, mcif2ACT_rd_rsp_pd);
    check("rdy_pass", mcif2ACT_rd_rsp_rdy, dat_out_rdy);
    if (g_block) check("credit_block_vld", ACT2mcif_rd_req_vld, 1'b0);
    if (ACT2mcif_rd_req_vld && stalled) check("pd_hold", ACT2mcif_rd_req_pd, prev_pd);
    if (ACT2mcif_rd_req_vld)
      check("credit", (model_out + int'(ACT2mcif_rd_req_pd[35:32]) + 1) <= MAXB, 1'b1);
    cf = ACT2mcif_rd_req_vld && ACT2mcif_rd_req_rdy;
    df = mcif2ACT_rd_rsp_vld && mcif2ACT_rd_rsp_rdy;
    if (cf) begin
      if (exp_q.size() == 0) begin
        check("extra_cmd", ACT2mcif_rd_req_pd, '0);
      end else begin
        e = exp_q.pop_front();
        check("cmd_addr", ACT2mcif_rd_req_pd[31:0], e.addr);
        check("cmd_len", ACT2mcif_rd_req_pd[35:32], e.len);
        pending   += int'(e.len) + 1;
        model_out += int'(e.len) + 1;
        fired++;
      end
    end
    if (df) begin
      sent_q.push_back(cur_data);
      pending--;
      holding = 0;
      if (model_out > 0) model_out--;
    end
    if (dat_out_vld && dat_out_rdy) recv_q.push_back(dat_out_pd);
    stalled = ACT2mcif_rd_req_vld && !ACT2mcif_rd_req_rdy;
    prev_pd = ACT2mcif_rd_req_pd;
    if (active && drain && model_out == 0) exp_done = 1;
    if (cf && active && exp_q.size() == 0) drain = 1;
    if (start && !active) begin
      active = 1; busy_exp = 1; drain = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    mcif2ACT_rd_rsp_vld = 1'b1;
    #1;
    check("rst_req_vld", ACT2mcif_rd_req_vld, 1'b0);
    check("rst_req_pd", ACT2mcif_rd_req_pd, '0);
    check("rst_done", rdma_done, 1'b0);
    check("rst_busy", rdma_busy, 1'b0);
    check("rst_dat_vld", dat_out_vld, 1'b1);
    mcif2ACT_rd_rsp_vld = 1'b0;
    reset_model();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int cw, input int ch_h, input int cch,
                     input int unsigned cbase, input int unsigned cls, input int unsigned css,
                     input int rq, input int dp, input int restart_at, input bit rst_drain,
                     input int block_cycles);
    bit finished;
    w = LOG2_W'(cw);
    h = LOG2_H'(ch_h);
    ch_div_Tout = CH_W'(cch);
    feature_base_addr      = cbase;
    feature_line_stride    = cls[15:0];
    feature_surface_stride = css[25:0];
    reset_model();
    build_model(cw, ch_h, cch, cbase, cls, css);
    start_req = 1;
    finished  = 0;
    for (int c = 0; c < 5000; c++) begin
      g_block = (c < block_cycles) && (fired > 0);
      cycle(rq, (c < block_cycles) ? 0 : dp);
      if (block_cycles > 0 && c == block_cycles - 1) check("credit_one_cmd", fired, 1);
      if (c == restart_at) start_req = 1;
      if (rst_drain && drain && active) begin
        do_reset();
        return;
      end
      if (c > 0 && !active) begin
        finished = 1;
        break;
      end
    end
    g_block = 0;
    if (!finished) check("timeout", 1'b0, 1'b1);
    check("cmds_left", exp_q.size(), 0);
    check("beat_count", recv_q.size(), total_beats);
    for (int i = 0; i < recv_q.size() && i < sent_q.size(); i++)
      check("beat_data", recv_q[i], sent_q[i]);
    for (int k = 0; k < 3; k++) cycle(100, 100);
  endtask

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    mcif2ACT_rd_rsp_vld = 1'b1;
    #1;
    check("reset_req_vld", ACT2mcif_rd_req_vld, 1'b0);
    check("reset_req_pd", ACT2mcif_rd_req_pd, '0);
    check("reset_done", rdma_done, 1'b0);
    check("reset_busy", rdma_busy, 1'b0);
    check("reset_dat_vld", dat_out_vld, 1'b1);
    mcif2ACT_rd_rsp_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(40, 2, 2, 32'h1000, 32'h1000, 32'h10000, 100, 100, -1, 0, 0);
    run(16, 1, 1, 32'h2000, 32'h100, 32'h4000, 100, 100, -1, 0, 0);
    run(64, 1, 1, 32'h0, 32'h0, 32'h0, 100, 100, -1, 0, 20);
    for (int r = 0; r < 4; r++)
      run($urandom_range(70, 1), $urandom_range(3, 1), $urandom_range(3, 1),
          $urandom, $urandom_range(16'hffff), $urandom_range(26'h3ffffff), 30, 50, -1, 0, 0);
    run(40, 2, 2, 32'h1000, 32'h1000, 32'h10000, 30, 50, 10, 0, 0);
    run(40, 2, 2, 32'h1000, 32'h1000, 32'h10000, 70, 40, -1, 1, 0);
    run(40, 2, 2, 32'h1000, 32'h1000, 32'h10000, 100, 100, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
